// File: rtl/eth_axis_rx.sv
// Ethernet frame receiver: splits an 8-bit AXI stream frame into parsed header
// fields (dest MAC, src MAC, ethertype) and a payload AXI stream.
`timescale 1ns/1ps
module eth_axis_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  error_header_early_termination
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned TYPE_W = 16;
  localparam int unsigned PTR_W  = 4;

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_axis_rx: only DATA_WIDTH = 8 is supported");
  end

  typedef enum logic {ST_HEADER = 1'b0, ST_PAYLOAD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [MAC_W-1:0]        dest_q, dest_d;
  logic [MAC_W-1:0]        src_q, src_d;
  logic [TYPE_W-1:0]       type_q, type_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic                    s_tready_q, s_tready_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    out_user_q, out_user_d;
  logic [DATA_WIDTH-1:0]   tmp_data_q, tmp_data_d;
  logic                    tmp_valid_q, tmp_valid_d;
  logic                    tmp_last_q, tmp_last_d;
  logic                    tmp_user_q, tmp_user_d;

  logic                    in_fire;
  logic                    pay_in;
  logic                    ready_early;

  // Header parse, payload skid buffer and registered input ready
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    hdr_valid_d = hdr_valid_q;
    err_d       = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    tmp_data_d  = tmp_data_q;
    tmp_valid_d = tmp_valid_q;
    tmp_last_d  = tmp_last_q;
    tmp_user_d  = tmp_user_q;
    pay_in      = 1'b0;
    in_fire     = s_axis_tvalid && s_tready_q;

    if (hdr_valid_q && m_eth_hdr_ready) begin
      hdr_valid_d = 1'b0;
    end

    if (state_q == ST_HEADER) begin
      if (in_fire) begin
        // Bytes arrive in order, so each field is a shift register
        if (ptr_q < PTR_W'(6)) begin
          dest_d = {dest_q[MAC_W-BYTE_W-1:0], BYTE_W'(s_axis_tdata)};
        end else if (ptr_q < PTR_W'(12)) begin
          src_d = {src_q[MAC_W-BYTE_W-1:0], BYTE_W'(s_axis_tdata)};
        end else begin
          type_d = {type_q[TYPE_W-BYTE_W-1:0], BYTE_W'(s_axis_tdata)};
        end

        if (s_axis_tlast) begin
          ptr_d = '0;
          err_d = 1'b1;
        end else if (ptr_q == PTR_W'(13)) begin
          ptr_d       = '0;
          hdr_valid_d = 1'b1;
          state_d     = ST_PAYLOAD;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
    end else begin
      if (in_fire) begin
        pay_in = 1'b1;
        if (s_axis_tlast) begin
          state_d = ST_HEADER;
        end
      end
    end

    ready_early = m_eth_payload_axis_tready ||
                  (!tmp_valid_q && (!out_valid_q || !pay_in));

    // Two-entry skid: fill output register first, overflow into temp
    if (pay_in) begin
      if (m_eth_payload_axis_tready || !out_valid_q) begin
        out_data_d  = s_axis_tdata;
        out_valid_d = 1'b1;
        out_last_d  = s_axis_tlast;
        out_user_d  = s_axis_tuser;
      end else begin
        tmp_data_d  = s_axis_tdata;
        tmp_valid_d = 1'b1;
        tmp_last_d  = s_axis_tlast;
        tmp_user_d  = s_axis_tuser;
      end
    end else if (m_eth_payload_axis_tready || !out_valid_q) begin
      out_data_d  = tmp_data_q;
      out_valid_d = tmp_valid_q;
      out_last_d  = tmp_last_q;
      out_user_d  = tmp_user_q;
      tmp_valid_d = 1'b0;
    end

    s_tready_d = (state_d == ST_PAYLOAD) ? ready_early : !hdr_valid_d;
    busy_d     = (state_d == ST_PAYLOAD) || (ptr_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HEADER;
      ptr_q       <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      hdr_valid_q <= 1'b0;
      s_tready_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      tmp_data_q  <= '0;
      tmp_valid_q <= 1'b0;
      tmp_last_q  <= 1'b0;
      tmp_user_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      hdr_valid_q <= hdr_valid_d;
      s_tready_q  <= s_tready_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      tmp_data_q  <= tmp_data_d;
      tmp_valid_q <= tmp_valid_d;
      tmp_last_q  <= tmp_last_d;
      tmp_user_q  <= tmp_user_d;
    end
  end

  assign s_axis_tready                  = s_tready_q;
  assign m_eth_hdr_valid                = hdr_valid_q;
  assign m_eth_dest_mac                 = dest_q;
  assign m_eth_src_mac                  = src_q;
  assign m_eth_type                     = type_q;
  assign m_eth_payload_axis_tdata       = out_data_q;
  assign m_eth_payload_axis_tvalid      = out_valid_q;
  assign m_eth_payload_axis_tlast       = out_last_q;
  assign m_eth_payload_axis_tuser       = out_user_q;
  assign busy                           = busy_q;
  assign error_header_early_termination = err_q;

endmodule

// File: doc/eth_axis_rx.md
Name: eth_axis_rx

Overview:
- Receive-direction counterpart of the Ethernet frame transmitter, 8-bit datapath.
- Takes a raw Ethernet frame on an AXI stream slave and parses the 14-byte header (dest MAC, src MAC, ethertype) into parallel fields with a valid/ready handshake.
- Forwards the remaining bytes as a payload AXI stream.
- Sits between the MAC receive FIFO and the protocol demux.

Parameters:
- DATA_WIDTH, 8, stream width in bits. Only 8 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  8  frame byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  frame error marker, meaningful with tlast
- m_eth_hdr_valid  out  1  header fields valid
- m_eth_hdr_ready  in  1  header consumer ready
- m_eth_dest_mac  out  48  bytes 0..5, byte 0 in [47:40]
- m_eth_src_mac  out  48  bytes 6..11, byte 6 in [47:40]
- m_eth_type  out  16  bytes 12..13, byte 12 in [15:8]
- m_eth_payload_axis_tdata  out  8  payload byte
- m_eth_payload_axis_tvalid  out  1  payload valid
- m_eth_payload_axis_tready  in  1  payload ready
- m_eth_payload_axis_tlast  out  1  last payload byte
- m_eth_payload_axis_tuser  out  1  forwarded tuser
- busy  out  1  frame in progress
- error_header_early_termination  out  1  one-cycle pulse

Behaviour:
- Reset (async assert):
  - All outputs go to 0, including s_axis_tready; header field registers are cleared.
  - State = HEADER, ptr = 0, payload skid buffer empty.
  - s_axis_tready rises on the first clock edge after rst deasserts.
- State HEADER, 4-bit byte pointer ptr 0..13:
  - s_axis_tready = !m_eth_hdr_valid. The next frame's header is not accepted while the previous header is unconsumed.
  - Each accepted byte is written to the field slot selected by ptr; ptr increments.
  - Accepted byte with tlast and ptr <= 13: frame is discarded, error_header_early_termination pulses the next cycle, ptr returns to 0, m_eth_hdr_valid does not rise, and no payload is emitted. A frame of exactly 14 bytes is therefore an error.
  - ptr == 13 accepted without tlast: m_eth_hdr_valid = 1 on the next cycle, state goes to PAYLOAD, ptr = 0.
  - tuser on header bytes is ignored.
- Header output:
  - Fields are stable while m_eth_hdr_valid = 1.
  - m_eth_hdr_valid clears on the cycle after the valid && ready handshake.
  - Header handshake is independent of payload flow; payload may stream before the header is consumed.
- State PAYLOAD:
  - Bytes pass through a 2-entry skid buffer (output register plus temp register).
  - s_axis_tready is registered, computed as m_eth_payload_axis_tready || (temp empty && (output empty || no input this cycle)). It is never combinationally dependent on m_eth_payload_axis_tready.
  - Latency is 1 cycle from input accept to m_eth_payload_axis_tvalid.
  - tdata, tlast and tuser are forwarded unchanged. No bytes are dropped or duplicated under any tready pattern.
  - When the tlast byte is accepted, state returns to HEADER on the next cycle. That byte's output may still be pending in the buffer; the new frame's header bytes may enter the parser while it drains.
- busy = (state == PAYLOAD) || (ptr != 0).
- Async reset mid-frame aborts immediately with no pulse. Any partial payload in the buffer is lost and tvalid drops.

Test Plan:
- Basic frame: dest 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, payload AA BB CC DD with tlast on DD, all readies high.
  -> m_eth_hdr_valid one cycle after byte 13 with m_eth_dest_mac=48'h020000000001, m_eth_src_mac=48'h020000000002, m_eth_type=16'h0800.
  -> Payload AA,BB,CC,DD with tlast only on DD, first payload byte one cycle after its accept.
- Payload backpressure: 64-byte payload (0x00..0x3F), m_eth_payload_axis_tready random 50%.
  -> Output sequence exactly 0x00..0x3F, tlast on 0x3F.
  -> s_axis_tready never high while both buffer entries are full.
- Early termination: tlast on byte index 5, then a valid frame as in the basic case.
  -> error pulse exactly 1 cycle; no hdr_valid and no payload for the short frame; second frame parsed correctly.
  -> A 14-byte frame also pulses the error.
- Header stall: m_eth_hdr_ready=0, two back-to-back frames.
  -> Frame 1 payload flows; s_axis_tready=0 at frame 2 byte 0 until one cycle after hdr_ready pulses.
  -> Frame 1 fields are held constant throughout.
- tuser forwarding: tuser=1 with tlast on last payload byte 0x5A.
  -> m_eth_payload_axis_tuser=1 with tlast on 0x5A.
  -> tuser=1 on header byte 3 has no effect.
- Reset mid-payload: assert rst after 3 payload bytes.
  -> All outputs 0 immediately (asynchronously); busy=0.
  -> After release, the next full frame is parsed correctly.
